// File: rtl/cache_types_pkg.sv
// cache_types_pkg: shared geometry and FSM state type for the cache line adapter
package cache_types_pkg;
  localparam int s_offset = 5;
  localparam int s_line = 256;
  localparam int s_beat = 64;
  localparam int n_beats = s_line / s_beat;
  localparam int cnt_w = $clog2(n_beats);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} adapter_state_t;
endpackage

// File: rtl/line_buffer.sv
// line_buffer: one cache line register with whole-line load, per-beat write and beat-select read
// Ports: clk, rst (sync, active-high); load/line_in replace the whole line;
//   beat_we/beat_in write slot sel; line is the stored line, beat is slot sel of it.
module line_buffer
  import cache_types_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [s_line-1:0] line_in,
  input  logic              beat_we,
  input  logic [cnt_w-1:0]  sel,
  input  logic [s_beat-1:0] beat_in,
  output logic [s_line-1:0] line,
  output logic [s_beat-1:0] beat
);
  logic [s_line-1:0] data;
  always_ff @(posedge clk) begin
    if (rst) data <= '0;
    else if (load) data <= line_in;
    else if (beat_we) data[sel*s_beat +: s_beat] <= beat_in;
  end
  assign line = data;
  assign beat = data[sel*s_beat +: s_beat];
endmodule

// File: rtl/cacheline_adapter.sv
// cacheline_adapter: turns one cache line read/write into a burst of beats on the memory bus
// Ports: clk, rst (sync, active-high); pmem_* line-side request/response;
//   burst_* beat-side request/data/handshake.
// CACHELINE_ADAPTER_PERF_EN adds perf_reads, perf_writes, perf_busy_cycles counters.
module cacheline_adapter
  import cache_types_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
`ifdef CACHELINE_ADAPTER_PERF_EN
  output logic [31:0]       perf_reads,
  output logic [31:0]       perf_writes,
  output logic [31:0]       perf_busy_cycles,
`endif
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [31:0]       pmem_address,
  input  logic [s_line-1:0] pmem_wdata,
  output logic [s_line-1:0] pmem_rdata,
  output logic              pmem_resp,
  output logic              burst_read,
  output logic              burst_write,
  output logic [31:0]       burst_address,
  output logic [s_beat-1:0] burst_wdata,
  input  logic [s_beat-1:0] burst_rdata,
  input  logic              burst_resp
);
  adapter_state_t state, state_n;
  logic [cnt_w-1:0] cnt;
  logic busy, last, accept, unused_bits;
  logic [s_beat-1:0] rbuf_beat;
  logic [s_line-1:0] wbuf_line;
  assign busy = state == READ || state == WRITE;
  assign last = busy && burst_resp && cnt == cnt_w'(n_beats - 1);
  assign accept = state == IDLE && (pmem_read || pmem_write);
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // write wins over read so a dirty eviction goes out before the refill
  always_comb begin
    state_n = state == IDLE ? (pmem_write ? WRITE : pmem_read ? READ : IDLE) :
              state == RESP ? IDLE : last ? RESP : state;
  end
  always_comb begin
    burst_read = state == READ;
    burst_write = state == WRITE;
    pmem_resp = state == RESP;
  end
  always_ff @(posedge clk) begin
    if (rst || !busy) cnt <= '0;
    else if (burst_resp) cnt <= last ? '0 : cnt + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) burst_address <= '0;
    else if (accept) burst_address <= {pmem_address[31:s_offset], {s_offset{1'b0}}};
  end
  line_buffer rbuf (
    .clk(clk), .rst(rst), .load(1'b0), .line_in('0),
    .beat_we(state == READ && burst_resp), .sel(cnt), .beat_in(burst_rdata),
    .line(pmem_rdata), .beat(rbuf_beat)
  );
  line_buffer wbuf (
    .clk(clk), .rst(rst), .load(accept && pmem_write), .line_in(pmem_wdata),
    .beat_we(1'b0), .sel(cnt), .beat_in('0),
    .line(wbuf_line), .beat(burst_wdata)
  );
  assign unused_bits = ^{rbuf_beat, wbuf_line, pmem_address[s_offset-1:0]};
`ifdef CACHELINE_ADAPTER_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_reads <= '0;
      perf_writes <= '0;
      perf_busy_cycles <= '0;
    end else begin
      perf_reads <= perf_reads + {31'b0, state == READ && last};
      perf_writes <= perf_writes + {31'b0, state == WRITE && last};
      perf_busy_cycles <= perf_busy_cycles + {31'b0, state != IDLE};
    end
  end
`endif
endmodule

// File: tb/tb_cacheline_adapter.sv
// tb_cacheline_adapter: scoreboard bench driving directed line transactions against a beat memory model
module tb_cacheline_adapter;
  logic clk = 0, rst = 1;
  logic pmem_read = 0, pmem_write = 0;
  logic [31:0] pmem_address = '0;
  logic [255:0] pmem_wdata = '0, pmem_rdata;
  logic pmem_resp, burst_read, burst_write;
  logic [31:0] burst_address;
  logic [63:0] burst_wdata, burst_rdata = '0;
  logic burst_resp = 0;
`ifdef CACHELINE_ADAPTER_PERF_EN
  logic [31:0] perf_reads, perf_writes, perf_busy_cycles;
`endif
  cacheline_adapter dut (
    .clk(clk), .rst(rst),
`ifdef CACHELINE_ADAPTER_PERF_EN
    .perf_reads(perf_reads), .perf_writes(perf_writes), .perf_busy_cycles(perf_busy_cycles),
`endif
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .burst_read(burst_read), .burst_write(burst_write), .burst_address(burst_address),
    .burst_wdata(burst_wdata), .burst_rdata(burst_rdata), .burst_resp(burst_resp)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0]  addr;
    logic [255:0] rdata;
    int           req_cycles;
  } exp_t;
  exp_t exp_q[$];
  logic [63:0] wbeat_q[$];
  logic [63:0] mem_beats [4];
  logic [255:0] last_line = '0;
  int stall = 0, wait_cnt = 0, beat_idx = 0, req_cyc = 0;
  int n_vec = 0, n_err = 0;
  logic prev_resp = 0;
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // memory model: answers each beat after `stall` idle cycles, checks write beats in order
  initial forever begin
    @(posedge clk);
    #2;
    burst_resp = 0;
    burst_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    if (rst || !(burst_read || burst_write)) begin
      wait_cnt = 0;
      beat_idx = 0;
    end else if (wait_cnt < stall) wait_cnt++;
    else begin
      wait_cnt = 0;
      burst_resp = 1;
      if (burst_read) burst_rdata = beat_idx < 4 ? mem_beats[beat_idx] : '1;
      if (burst_write) begin
        if (wbeat_q.size() == 0) check("extra_write_beat", 256'(burst_wdata), '1);
        else check("write_beat", 256'(burst_wdata), 256'(wbeat_q.pop_front()));
      end
      beat_idx++;
    end
  end
  // response monitor: pops the scoreboard on every pmem_resp
  initial forever begin
    @(negedge clk);
    if (pmem_resp && prev_resp) check("resp_pulse_width", 256'(2), 256'(1));
    prev_resp = pmem_resp;
    if (rst) req_cyc = 0;
    else if (burst_read || burst_write) req_cyc++;
    if (pmem_resp && !rst) begin
      if (exp_q.size() == 0) check("unexpected_resp", 256'(1), 256'(0));
      else begin
        exp_t e;
        e = exp_q.pop_front();
        check("burst_address", 256'(burst_address), 256'(e.addr));
        check("pmem_rdata", pmem_rdata, e.rdata);
        check("burst_req_cycles", 256'(req_cyc), 256'(e.req_cycles));
        check("req_low_in_resp", 256'({burst_read, burst_write}), 256'(0));
      end
      req_cyc = 0;
    end
  end
  task automatic txn(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [255:0] wd, input logic [255:0] rline, input int s);
    int got = 0, need;
    logic [255:0] w;
    w = wd;
    need = int'(rd) + int'(wr);
    stall = s;
    for (int i = 0; i < 4; i++) mem_beats[i] = rline[i*64 +: 64];
    if (wr) begin
      exp_q.push_back('{a & 32'hFFFF_FFE0, last_line, 4 * (s + 1)});
      for (int i = 0; i < 4; i++) wbeat_q.push_back(w[i*64 +: 64]);
    end
    if (rd) begin
      exp_q.push_back('{a & 32'hFFFF_FFE0, rline, 4 * (s + 1)});
      last_line = rline;
    end
    @(posedge clk);
    #1;
    pmem_read = rd;
    pmem_write = wr;
    pmem_address = a;
    pmem_wdata = wd;
    for (int c = 0; c < 300 && got < need; c++) begin
      @(posedge clk);
      #1;
      if (pmem_resp) begin
        got++;
        pmem_write = 0;
        if (got == need) pmem_read = 0;
      end
    end
    if (got < need) begin
      check("txn_timeout", 256'(got), 256'(need));
      pmem_read = 0;
      pmem_write = 0;
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_burst_read", 256'(burst_read), 0);
    check("rst_burst_write", 256'(burst_write), 0);
    check("rst_pmem_resp", 256'(pmem_resp), 0);
    check("rst_burst_address", 256'(burst_address), 0);
    check("rst_pmem_rdata", pmem_rdata, 0);
    rst = 0;
    txn(1, 0, 32'h0000_1234, '0,
        {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 0);
    txn(0, 1, 32'h8000_00E0,
        {64'hD3D3_0003_D3D3_0003, 64'hD2D2_0002_D2D2_0002, 64'hD1D1_0001_D1D1_0001, 64'hD0D0_0000_D0D0_0000}, '0, 0);
    txn(1, 0, 32'h0000_4567, '0,
        {64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C, 64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A}, 3);
    txn(1, 1, 32'h0000_2040,
        {64'h5757_5757_0000_0004, 64'h5757_5757_0000_0003, 64'h5757_5757_0000_0002, 64'h5757_5757_0000_0001},
        {64'h9898_9898_0000_0040, 64'h9898_9898_0000_0030, 64'h9898_9898_0000_0020, 64'h9898_9898_0000_0010}, 0);
    stall = 0;
    for (int i = 0; i < 4; i++) mem_beats[i] = 64'h0F0F_0000_0000_0000 + 64'(i);
    @(posedge clk);
    #1;
    pmem_address = 32'h0000_3000;
    pmem_read = 1;
    for (int c = 0; c < 50 && beat_idx != 2; c++) begin
      @(posedge clk);
      #3;
    end
    check("abort_reached_beat2", 256'(beat_idx), 256'(2));
    @(posedge clk);
    #1;
    rst = 1;
    pmem_read = 0;
    @(posedge clk);
    #1;
    check("abort_burst_read", 256'(burst_read), 0);
    check("abort_pmem_resp", 256'(pmem_resp), 0);
    check("abort_burst_address", 256'(burst_address), 0);
    check("abort_pmem_rdata", pmem_rdata, 0);
    rst = 0;
    last_line = '0;
    txn(1, 0, 32'hFFFF_FFFF, '0,
        {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h0000_FFFF_0000_FFFF, 64'h8000_0000_0000_0001}, 1);
`ifdef CACHELINE_ADAPTER_PERF_EN
    @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    last_line = '0;
    txn(1, 0, 32'h0000_0100, '0, {4{64'h1}}, 0);
    txn(1, 0, 32'h0000_0200, '0, {4{64'h2}}, 0);
    txn(0, 1, 32'h0000_0300, {4{64'h3}}, '0, 0);
    @(posedge clk);
    #1;
    check("perf_reads", 256'(perf_reads), 256'(2));
    check("perf_writes", 256'(perf_writes), 256'(1));
    check("perf_busy_cycles", 256'(perf_busy_cycles), 256'(15));
`endif
    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", 256'(exp_q.size()), 0);
    check("write_beats_drained", 256'(wbeat_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
